// File: rtl/clean_pulse_meter_pkg.sv
// clean_pulse_meter_pkg: state encoding and default widths shared by the pulse meter files
package clean_pulse_meter_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam int CNT_W_DEF  = 32;
  localparam int DROP_W_DEF = 16;
endpackage

// File: rtl/clean_pulse_meter_sat.sv
// sat_counter: counter that loads to 1 and saturates at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);
  assign sat = &q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) q <= '0;
    else if (load) q <= W'(1);
    else if (inc && !sat) q <= q + 1'b1;
endmodule

// File: rtl/clean_pulse_meter.sv
// clean_pulse_meter: measures high time and rise-to-rise period of a clean level
// and offers each result on a single-entry valid/ready output register.
module clean_pulse_meter
  import clean_pulse_meter_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clean,
  input  logic              en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  m_high,
  output logic [CNT_W-1:0]  m_period,
  output logic              m_ovf,
  output logic [DROP_W-1:0] drop_cnt
);
  logic             r_clean_d, r_valid, r_ovf;
  logic [1:0]       r_state, w_next;
  logic [CNT_W-1:0] r_high, r_period, w_hi, w_per;
  logic             w_rise, w_fall, w_done, w_load, w_hi_inc, w_per_inc;
  logic             w_hi_sat, w_per_sat, w_drop_inc, w_drop_sat;

  assign w_rise     = clean & ~r_clean_d;
  assign w_fall     = ~clean & r_clean_d;
  assign w_done     = en & (r_state == ST_LOW) & w_rise;
  assign w_load     = en & w_rise & (r_state == ST_IDLE || r_state == ST_LOW);
  assign w_hi_inc   = en & (r_state == ST_HIGH) & ~w_fall;
  assign w_per_inc  = en & (r_state == ST_HIGH || r_state == ST_LOW);
  assign w_drop_inc = w_done & r_valid & ~m_ready & ~w_drop_sat;

  always_comb
    w_next = !en ? ST_IDLE :
             (r_state == ST_IDLE && w_rise) ? ST_HIGH :
             (r_state == ST_HIGH && w_fall) ? ST_LOW :
             (r_state == ST_LOW && w_rise) ? ST_HIGH :
             (r_state == ST_HIGH || r_state == ST_LOW) ? r_state : ST_IDLE;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_clean_d <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      r_clean_d <= clean;
      r_state   <= w_next;
    end

  // A completion is taken whenever the slot is free or being emptied this cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_high   <= '0;
      r_period <= '0;
      r_ovf    <= 1'b0;
    end else if (w_done && (!r_valid || m_ready)) begin
      r_valid  <= 1'b1;
      r_high   <= w_hi;
      r_period <= w_per;
      r_ovf    <= w_hi_sat | w_per_sat;
    end else if (m_ready) begin
      r_valid  <= 1'b0;
    end

  sat_counter #(.W(CNT_W)) u_hi_cnt (
    .clk(clk), .resetn(resetn), .load(w_load), .inc(w_hi_inc), .q(w_hi), .sat(w_hi_sat)
  );
  sat_counter #(.W(CNT_W)) u_per_cnt (
    .clk(clk), .resetn(resetn), .load(w_load), .inc(w_per_inc), .q(w_per), .sat(w_per_sat)
  );
  sat_counter #(.W(DROP_W)) u_drop_cnt (
    .clk(clk), .resetn(resetn), .load(1'b0), .inc(w_drop_inc), .q(drop_cnt), .sat(w_drop_sat)
  );

  assign m_valid  = r_valid;
  assign m_high   = r_high;
  assign m_period = r_period;
  assign m_ovf    = r_ovf;
endmodule
